// File: rtl/actor_result_source_if.sv
// Token handshake between actor_result_source and its consumer:
// the source offers DATA/COUNT with SEND, the consumer answers with ACK/RDY.
interface actor_result_source_if;
  logic [7:0]  DATA;
  logic [15:0] COUNT;
  logic        SEND;
  logic        ACK;
  logic        RDY;

  modport master (output DATA, COUNT, SEND, input ACK, RDY);
  modport slave  (input DATA, COUNT, SEND, output ACK, RDY);
endinterface

// File: rtl/actor_result_source.sv
// Free-running token source: emits START_VALUE, START_VALUE+STEP, ... on a SEND/ACK handshake.
// Define ACTOR_SOURCE_LIMIT_EN to stop in DONE after MAX_TOKENS transfers (0 = unlimited).
module actor_result_source #(
  parameter logic [7:0]  START_VALUE = 8'h00,
  parameter logic [7:0]  STEP        = 8'h01,
  parameter logic [15:0] MAX_TOKENS  = 16'd16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  actor_result_source_if.master        result,
  output logic                         done
);

`ifdef ACTOR_SOURCE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {KICK0, KICK1, WAIT, OFFER, DONE} state_t;

  state_t      state;
  logic [7:0]  data_q;
  logic [15:0] tok_cnt;
  logic [7:0]  data_nxt;
  logic [15:0] cnt_nxt;
  logic        limit_hit;

  function automatic logic [7:0] step_data(input logic [7:0] d);
    return d + STEP;
  endfunction

  function automatic logic reached_limit(input logic [15:0] c);
    return LIMIT_EN && (MAX_TOKENS != 16'd0) && (c == MAX_TOKENS);
  endfunction

  assign data_nxt  = step_data(data_q);
  assign cnt_nxt   = tok_cnt + 16'd1;
  assign limit_hit = reached_limit(cnt_nxt);

`ifndef ACTOR_SOURCE_LIMIT_EN
  assign done = 1'b0;
`endif

  // All outputs are registered; SEND/DATA only change on a transfer or leaving WAIT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= KICK0;
      data_q       <= START_VALUE;
      tok_cnt      <= 16'd0;
      result.SEND  <= 1'b0;
      result.COUNT <= 16'd0;
      result.DATA  <= START_VALUE;
`ifdef ACTOR_SOURCE_LIMIT_EN
      done         <= 1'b0;
`endif
    end else begin
      case (state)
        KICK0: state <= KICK1;
        KICK1: state <= WAIT;
        WAIT: begin
          if (result.RDY) begin
            state        <= OFFER;
            result.SEND  <= 1'b1;
            result.DATA  <= data_q;
            result.COUNT <= 16'd1;
          end
        end
        OFFER: begin
          if (result.ACK) begin
            data_q  <= data_nxt;
            tok_cnt <= cnt_nxt;
            if (limit_hit) begin
              state        <= DONE;
              result.SEND  <= 1'b0;
              result.COUNT <= 16'd0;
`ifdef ACTOR_SOURCE_LIMIT_EN
              done         <= 1'b1;
`endif
            end else if (result.RDY) begin
              result.DATA <= data_nxt;
            end else begin
              state        <= WAIT;
              result.SEND  <= 1'b0;
              result.COUNT <= 16'd0;
            end
          end
        end
        DONE: state <= DONE;
        default: state <= KICK0;
      endcase
    end
  end

endmodule

// File: doc/actor_result_source.md
ACTOR_RESULT_SOURCE -- requirements
Module: actor_result_source

Interface
REQ-001 SHALL have parameter START_VALUE, default 8'h00, data of the first token after reset.
REQ-002 SHALL have parameter STEP, default 8'h01, increment applied to data after each accepted token.
REQ-003 SHALL have parameter MAX_TOKENS, default 16'd16, token limit; used only when ACTOR_SOURCE_LIMIT_EN is defined.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port result_DATA  output  8  token value, valid while result_SEND=1.
REQ-007 SHALL have port result_COUNT  output  16  16'd1 while result_SEND=1, else 16'd0.
REQ-008 SHALL have port result_SEND  output  1  token offered to consumer.
REQ-009 SHALL have port result_ACK  input  1  consumer accepts the offered token.
REQ-010 SHALL have port result_RDY  input  1  consumer has space for a token.
REQ-011 SHALL have port done  output  1  token limit reached.

Function
REQ-012 SHALL implement states KICK0, KICK1, WAIT, OFFER, DONE.
REQ-013 KICK0 -> KICK1 -> WAIT on consecutive rising edges after RESET deasserts, i.e. a two-cycle start kick; no output activity during the kick.
REQ-014 WAIT: result_SEND=0; on an edge with result_RDY=1 -> OFFER.
REQ-015 OFFER: result_SEND=1, result_DATA=current data register, result_COUNT=16'd1; outputs are registered, not combinational from inputs.
REQ-016 Transfer occurs on a rising edge where result_SEND=1 and result_ACK=1.
REQ-017 Once asserted, result_SEND and result_DATA SHALL hold unchanged until the transfer; result_RDY falling does not withdraw an offer.
REQ-018 On transfer: data register += STEP, modulo 256 (wraps FF->00 for STEP=1); token counter += 1 (16-bit).
REQ-019 On transfer with result_RDY=1 -> remain OFFER with the next data: back-to-back, one token per cycle while ACK and RDY are held high.
REQ-020 On transfer with result_RDY=0 -> WAIT.
REQ-021 result_ACK while result_SEND=0 SHALL be ignored, with no state or counter change.
REQ-022 DONE: result_SEND=0, result_COUNT=0, done=1; terminal until reset.

Reset
REQ-023 RESET=1 SHALL asynchronously force state KICK0, data register=START_VALUE, token counter=0, result_SEND=0, result_COUNT=0, result_DATA=START_VALUE, done=0.
REQ-024 RESET asserted mid-offer SHALL drop result_SEND immediately, without waiting for a clock edge; the pending token is discarded, not counted.
REQ-025 After RESET deasserts, the full two-cycle kick of REQ-013 SHALL repeat.

Configuration
REQ-026 Macro ACTOR_SOURCE_LIMIT_EN defined: a transfer making token counter == MAX_TOKENS -> DONE instead of OFFER/WAIT; MAX_TOKENS=0 means no limit.
REQ-027 Macro ACTOR_SOURCE_LIMIT_EN undefined: the block never enters DONE, done is tied 0, and the counter wraps modulo 2^16 with no effect on behaviour.

Verification
REQ-028 Reset release, RDY=1, ACK=0 -> SEND=0 for the two kick cycles, then SEND=1, DATA=00, COUNT=1, held for 10 cycles with no ACK.
REQ-029 RDY=1, ACK=1 continuously, defaults -> DATA sequence 00,01,02,... one per cycle; with ACTOR_SOURCE_LIMIT_EN, exactly 16 transfers (00..0F), then SEND=0 and done=1.
REQ-030 START_VALUE=8'hFE, STEP=8'h01, macro undefined, ACK held high -> DATA sequence FE,FF,00,01 (wrap-around); done stays 0.
REQ-031 Offer active, RDY drops to 0 before ACK -> SEND and DATA held; ACK pulses -> SEND=0 next cycle; RDY=1 -> next token offered with DATA+STEP.
REQ-032 ACK pulsed during the kick and WAIT states -> no DATA advance; the first transferred token is still START_VALUE.
REQ-033 RESET asserted between clock edges while SEND=1, DATA=05 -> SEND=0 and DATA=START_VALUE before the next edge; after release, a two-cycle kick, then DATA=START_VALUE.
